// File: rtl/pipe_phy_detect_responder.sv
// rtl/pipe_phy_detect_responder.sv - behavioural PIPE PHY answering reset, receiver-detect and PowerDown handshakes
module pipe_phy_detect_responder #(
    parameter int RESET_LATENCY  = 4,
    parameter int DETECT_LATENCY = 8,
    parameter int PD_LATENCY     = 5
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       TxDetectRx_Loopback,
    input  logic [3:0] PowerDown,
    input  logic       TxElecIdle,
    input  logic       rx_present,
    output logic       PhyStatus,
    output logic [2:0] RxStatus,
    output logic       RxElecIdle,
    output logic [3:0] pd_current,
    output logic       loopback_active,
    output logic       pd_error
);

    localparam int MAX_LAT_A = (RESET_LATENCY > DETECT_LATENCY) ? RESET_LATENCY : DETECT_LATENCY;
    localparam int MAX_LAT   = (MAX_LAT_A > PD_LATENCY) ? MAX_LAT_A : PD_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_LATENCY);
    localparam logic [CNT_W-1:0] DET_CNT = CNT_W'(DETECT_LATENCY);
    localparam logic [CNT_W-1:0] PD_CNT  = CNT_W'(PD_LATENCY);

    localparam logic [3:0] PD_P0 = 4'b0000;
    localparam logic [3:0] PD_P1 = 4'b0010;
    localparam logic [3:0] PD_P2 = 4'b0011;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        DETECT,
        DET_HOLD,
        PD_CHANGE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       target_q, target_d;
    logic             phy_q, phy_d;
    logic [2:0]       rxs_q, rxs_d;
    logic             rxei_q, rxei_d;
    logic [3:0]       pd_cur_q, pd_cur_d;
    logic             lb_q, lb_d;
    logic             perr_q, perr_d;
    logic             inv_seen_q, inv_seen_d;
    logic [3:0]       inv_val_q, inv_val_d;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= RST_WAIT;
            cnt_q      <= '0;
            target_q   <= PD_P1;
            phy_q      <= 1'b1;
            rxs_q      <= 3'b000;
            rxei_q     <= 1'b1;
            pd_cur_q   <= PD_P1;
            lb_q       <= 1'b0;
            perr_q     <= 1'b0;
            inv_seen_q <= 1'b0;
            inv_val_q  <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            phy_q      <= phy_d;
            rxs_q      <= rxs_d;
            rxei_q     <= rxei_d;
            pd_cur_q   <= pd_cur_d;
            lb_q       <= lb_d;
            perr_q     <= perr_d;
            inv_seen_q <= inv_seen_d;
            inv_val_q  <= inv_val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        phy_d      = 1'b0;
        rxs_d      = 3'b000;
        pd_cur_d   = pd_cur_q;
        perr_d     = 1'b0;
        inv_seen_d = inv_seen_q;
        inv_val_d  = inv_val_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        // A valid PowerDown value re-arms the invalid-request reporting.
        if (PowerDown <= PD_P2) begin
            inv_seen_d = 1'b0;
        end

        case (state_q)
            RST_WAIT: begin
                if (cnt_q == RST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    phy_d = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                if (PowerDown != pd_cur_q) begin
                    if (PowerDown > PD_P2) begin
                        perr_d     = !inv_seen_q || (PowerDown != inv_val_q);
                        inv_seen_d = 1'b1;
                        inv_val_d  = PowerDown;
                    end else begin
                        target_d = PowerDown;
                        cnt_d    = CNT_W'(1);
                        state_d  = PD_CHANGE;
                    end
                end else if (TxDetectRx_Loopback && (pd_cur_q == PD_P1)) begin
                    cnt_d   = CNT_W'(1);
                    state_d = DETECT;
                end
            end
            DETECT: begin
                // Dropping the request aborts even on the would-be final cycle.
                if (!TxDetectRx_Loopback) begin
                    state_d = IDLE;
                end else if (cnt_q == DET_CNT) begin
                    phy_d   = 1'b1;
                    rxs_d   = rx_present ? 3'b011 : 3'b000;
                    state_d = DET_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DET_HOLD: begin
                if (!TxDetectRx_Loopback) begin
                    state_d = IDLE;
                end
            end
            PD_CHANGE: begin
                if (cnt_q == PD_CNT) begin
                    pd_cur_d = target_q;
                    phy_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = RST_WAIT;
        endcase

        lb_d   = (state_d == IDLE) && TxDetectRx_Loopback && (pd_cur_d == PD_P0);
        rxei_d = (pd_cur_d != PD_P0) || TxElecIdle || (state_d == RST_WAIT);
    end

    assign PhyStatus       = phy_q;
    assign RxStatus        = rxs_q;
    assign RxElecIdle      = rxei_q;
    assign pd_current      = pd_cur_q;
    assign loopback_active = lb_q;
    assign pd_error        = perr_q;

endmodule

// File: tb/tb_pipe_phy_detect_responder.sv
// tb/tb_pipe_phy_detect_responder.sv - scoreboard bench for pipe_phy_detect_responder
module tb_pipe_phy_detect_responder;

    localparam int RESET_LATENCY  = 4;
    localparam int DETECT_LATENCY = 8;
    localparam int PD_LATENCY     = 5;

    localparam int M_RST  = 0;
    localparam int M_IDLE = 1;
    localparam int M_DET  = 2;
    localparam int M_HOLD = 3;
    localparam int M_PD   = 4;

    typedef struct packed {
        logic       phy;
        logic [2:0] rxs;
        logic       rxei;
        logic [3:0] pdc;
        logic       lb;
        logic       perr;
    } obs_t;

    logic       pclk = 1'b0;
    logic       reset;
    logic       TxDetectRx_Loopback;
    logic [3:0] PowerDown;
    logic       TxElecIdle;
    logic       rx_present;
    logic       PhyStatus;
    logic [2:0] RxStatus;
    logic       RxElecIdle;
    logic [3:0] pd_current;
    logic       loopback_active;
    logic       pd_error;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    obs_t exp_q[$];

    int         m_mode = M_RST;
    int         m_rst_edges = 0;
    int         m_deadline = 0;
    logic [3:0] m_pd = 4'd2;
    logic [3:0] m_target = 4'd2;
    bit         m_inv_seen = 1'b0;
    logic [3:0] m_inv_val = 4'd0;

    pipe_phy_detect_responder #(
        .RESET_LATENCY (RESET_LATENCY),
        .DETECT_LATENCY(DETECT_LATENCY),
        .PD_LATENCY    (PD_LATENCY)
    ) dut (
        .pclk               (pclk),
        .reset              (reset),
        .TxDetectRx_Loopback(TxDetectRx_Loopback),
        .PowerDown          (PowerDown),
        .TxElecIdle         (TxElecIdle),
        .rx_present         (rx_present),
        .PhyStatus          (PhyStatus),
        .RxStatus           (RxStatus),
        .RxElecIdle         (RxElecIdle),
        .pd_current         (pd_current),
        .loopback_active    (loopback_active),
        .pd_error           (pd_error)
    );

    always #5 pclk = ~pclk;

    function automatic obs_t actual();
        obs_t a;
        a.phy  = PhyStatus;
        a.rxs  = RxStatus;
        a.rxei = RxElecIdle;
        a.pdc  = pd_current;
        a.lb   = loopback_active;
        a.perr = pd_error;
        return a;
    endfunction

    function automatic obs_t reset_values();
        obs_t r;
        r.phy  = 1'b1;
        r.rxs  = 3'b000;
        r.rxei = 1'b1;
        r.pdc  = 4'b0010;
        r.lb   = 1'b0;
        r.perr = 1'b0;
        return r;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got phy=%b rxs=%b rxei=%b pdc=%b lb=%b perr=%b, expected phy=%b rxs=%b rxei=%b pdc=%b lb=%b perr=%b",
                     name, cyc_cnt, act.phy, act.rxs, act.rxei, act.pdc, act.lb, act.perr,
                     exp.phy, exp.rxs, exp.rxei, exp.pdc, exp.lb, exp.perr);
        end
    endtask

    // Reference model: deadlines are absolute edge numbers counted from the accepting edge.
    task automatic model_step();
        obs_t e;
        cyc_cnt++;
        e.phy  = 1'b0;
        e.rxs  = 3'b000;
        e.perr = 1'b0;
        if (reset) begin
            m_mode      = M_RST;
            m_rst_edges = 0;
            m_pd        = 4'd2;
            m_inv_seen  = 1'b0;
            e = reset_values();
        end else begin
            if (PowerDown <= 4'd3) m_inv_seen = 1'b0;
            case (m_mode)
                M_RST: begin
                    m_rst_edges++;
                    if (m_rst_edges > RESET_LATENCY) m_mode = M_IDLE;
                    else e.phy = 1'b1;
                end
                M_IDLE: begin
                    if (PowerDown != m_pd) begin
                        if (PowerDown > 4'd3) begin
                            if (!(m_inv_seen && PowerDown == m_inv_val)) e.perr = 1'b1;
                            m_inv_seen = 1'b1;
                            m_inv_val  = PowerDown;
                        end else begin
                            m_target   = PowerDown;
                            m_deadline = cyc_cnt + PD_LATENCY;
                            m_mode     = M_PD;
                        end
                    end else if (TxDetectRx_Loopback && m_pd == 4'd2) begin
                        m_deadline = cyc_cnt + DETECT_LATENCY;
                        m_mode     = M_DET;
                    end
                end
                M_DET: begin
                    if (!TxDetectRx_Loopback) begin
                        m_mode = M_IDLE;
                    end else if (cyc_cnt == m_deadline) begin
                        e.phy  = 1'b1;
                        e.rxs  = rx_present ? 3'b011 : 3'b000;
                        m_mode = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (!TxDetectRx_Loopback) m_mode = M_IDLE;
                end
                default: begin
                    if (cyc_cnt == m_deadline) begin
                        m_pd   = m_target;
                        e.phy  = 1'b1;
                        m_mode = M_IDLE;
                    end
                end
            endcase
            e.pdc  = m_pd;
            e.lb   = (m_mode == M_IDLE) && TxDetectRx_Loopback && (m_pd == 4'd0);
            e.rxei = (m_pd != 4'd0) || TxElecIdle || (m_mode == M_RST);
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge pclk);
            model_step();
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle %0d: got 0 entries, expected 1", cyc_cnt);
            end else begin
                e = exp_q.pop_front();
                compare("cycle_outputs", actual(), e);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    initial begin
        reset               = 1'b1;
        TxDetectRx_Loopback = 1'b0;
        PowerDown           = 4'd2;
        TxElecIdle          = 1'b1;
        rx_present          = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(12);

        rx_present = 1'b1;
        TxDetectRx_Loopback = 1'b1;
        wait_cycles(20);
        TxDetectRx_Loopback = 1'b0;
        wait_cycles(4);

        rx_present = 1'b0;
        TxDetectRx_Loopback = 1'b1;
        wait_cycles(20);
        TxDetectRx_Loopback = 1'b0;
        wait_cycles(4);

        PowerDown = 4'd0;
        wait_cycles(10);
        TxElecIdle = 1'b1;
        wait_cycles(4);
        TxElecIdle = 1'b0;
        wait_cycles(4);
        TxDetectRx_Loopback = 1'b1;
        wait_cycles(5);
        TxDetectRx_Loopback = 1'b0;
        wait_cycles(2);
        TxElecIdle = 1'b1;

        PowerDown = 4'd2;
        wait_cycles(10);
        TxDetectRx_Loopback = 1'b1;
        wait_cycles(3);
        TxDetectRx_Loopback = 1'b0;
        wait_cycles(4);
        PowerDown = 4'd5;
        wait_cycles(5);
        PowerDown = 4'd2;
        wait_cycles(4);

        rx_present = 1'b1;
        TxDetectRx_Loopback = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        #1;
        compare("reset_immediate", actual(), reset_values());
        wait_cycles(2);
        reset = 1'b0;
        TxDetectRx_Loopback = 1'b0;
        wait_cycles(12);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) TxDetectRx_Loopback = ~TxDetectRx_Loopback;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 9) == 0) PowerDown = 4'($urandom_range(4, 15));
                else PowerDown = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) TxElecIdle = ~TxElecIdle;
            rx_present = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 599) == 0);
            @(negedge pclk);
        end
        reset = 1'b0;
        wait_cycles(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_phy_detect_responder.md
Name: pipe_phy_detect_responder

Overview:
- PHY-side responder for the PIPE control interface.
- Consumes the MAC's TxDetectRx_Loopback, PowerDown and TxElecIdle.
- Answers with PhyStatus/RxStatus handshakes for reset completion, receiver detection and power-state changes.
- Used as the behavioural PHY in TX-path benches and as the PHY stub in integrated MAC simulation.

Parameters:
- RESET_LATENCY, 4: cycles PhyStatus stays high after reset deasserts (min 1).
- DETECT_LATENCY, 8: cycles from accepted detect request to completion pulse (min 1).
- PD_LATENCY, 5: cycles from accepted PowerDown change to completion pulse (min 1).

Ports:
- pclk  input  1  PIPE clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- TxDetectRx_Loopback  input  1  detect request (in P1) or loopback request (in P0).
- PowerDown  input  4  requested power state; valid 0000=P0, 0001=P0s, 0010=P1, 0011=P2.
- TxElecIdle  input  1  MAC transmitter electrical idle.
- rx_present  input  1  far-end receiver present (bench strap).
- PhyStatus  output  1  completion/ready indication.
- RxStatus  output  3  011 = receiver detected, else 000.
- RxElecIdle  output  1  modelled receive electrical idle.
- pd_current  output  4  power state currently in effect.
- loopback_active  output  1  loopback request honoured.
- pd_error  output  1  one-cycle pulse on an invalid PowerDown request.

Behaviour:
- All outputs registered.
- Reset values while reset=1: PhyStatus=1, RxStatus=000, RxElecIdle=1, pd_current=0010, loopback_active=0, pd_error=0, state=RST_WAIT, counter=0.
- Counter width: $clog2(max latency + 1); it saturates and never wraps.
- RST_WAIT:
  - PhyStatus held at 1 for RESET_LATENCY cycles after the first pclk edge with reset=0.
  - Then PhyStatus=0 and the state moves to IDLE.
  - Requests arriving during RST_WAIT are ignored; they are re-evaluated in IDLE.
- IDLE priority, evaluated every cycle:
  1. PowerDown != pd_current:
     - If PowerDown > 0011: pulse pd_error for 1 cycle, stay in IDLE. The request remains ignored while it persists; pd_error pulses once per new invalid value.
     - Otherwise latch the target and go to PD_CHANGE.
  2. Else if TxDetectRx_Loopback=1 and pd_current=0010: go to DETECT.
  3. Else stay in IDLE.
- loopback_active = TxDetectRx_Loopback and pd_current=0000, registered; 0 in all non-IDLE states.
- DETECT:
  - Count DETECT_LATENCY cycles from the accept cycle.
  - On the final cycle: PhyStatus=1 for exactly 1 cycle, with RxStatus=011 if rx_present=1 (sampled that cycle), else 000.
  - RxStatus returns to 000 the next cycle. Then go to DET_HOLD.
  - If TxDetectRx_Loopback drops before completion: abort to IDLE, no PhyStatus pulse, RxStatus stays 000.
  - PowerDown changes during DETECT are deferred; IDLE re-compares afterwards.
- DET_HOLD: wait for TxDetectRx_Loopback=0, then go to IDLE. No second detect while the request stays high.
- PD_CHANGE:
  - Count PD_LATENCY cycles.
  - On the final cycle: pd_current takes the latched target, PhyStatus=1 for 1 cycle, return to IDLE.
  - PowerDown changes mid-change are handled by IDLE afterwards.
  - TxDetectRx_Loopback is ignored during PD_CHANGE.
- RxElecIdle (registered) = 1 when pd_current != 0000, or TxElecIdle=1, or state is RST_WAIT.
- PhyStatus is never high for more than 1 consecutive cycle outside RST_WAIT.
- Reset asserted in any state: immediate return to reset values; any in-progress detect or PowerDown change is discarded.

Test Plan:
1. Reset high 3 cycles, then low -> PhyStatus=1 throughout reset and 4 further cycles, then 0; pd_current=0010, RxElecIdle=1.
2. pd_current=0010, TxDetectRx_Loopback=1, rx_present=1 -> exactly 8 cycles after accept, PhyStatus=1 and RxStatus=011 for 1 cycle; no repeat while the request is held; the request dropping returns to IDLE.
3. Same as 2 with rx_present=0 -> single PhyStatus pulse with RxStatus=000.
4. PowerDown 0010->0000 -> PhyStatus pulse 5 cycles after accept, pd_current=0000. Afterwards RxElecIdle tracks TxElecIdle (1->1, 0->0), and TxDetectRx_Loopback=1 gives loopback_active=1 with no PhyStatus.
5. Detect started, TxDetectRx_Loopback dropped at cycle 3 -> no PhyStatus, RxStatus=000. PowerDown=0101 -> one pd_error pulse, pd_current unchanged.
6. Reset asserted at cycle 4 of DETECT -> outputs at reset values immediately; the full RST_WAIT sequence follows; no stale detect pulse.
